multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control unit of the multi-cycle RV32I core; sits directly upstream of the immediate extender.
- Drives the extender's imm_src select from the instruction register opcode.
- Sequences fetch/decode/execute/memory/writeback through a Moore FSM and decodes ALU operations.
- Instruction subset: lw, sw, R-type ALU, I-type ALU, beq. This matches the I/S/B immediate formats the extender supports.

Parameters:
- None. All encodings are constants in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory access complete this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction/oldPC register load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result mux: 00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  out  2  ALU A: 00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  ALU B: 00=rs2, 01=imm_ext, 10=constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  to extender: 00 I, 01 S, 10 B
- illegal_instr  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Interface: one clock (clk). reset is asynchronous and active-high; it forces state FETCH immediately.
- While reset is high, pc_write, mem_write, ir_write, reg_write and illegal_instr are 0. All other outputs take their FETCH-state values.
- Outputs are combinational from the state register (Moore). Exceptions: pc_write uses zero/mem_ready; illegal_instr uses op.
- pc_write = pc_update OR (branch AND zero).
- imm_src is decoded from op in every state:
  - lw (0000011) and I-ALU (0010011) -> 00
  - sw (0100011) -> 01
  - beq (1100011) -> 10
  - any other opcode -> 00
- States and outputs. Unlisted enables are 0; unlisted mux selects are 00.
  - FETCH: adr_src=0, a=00, b=10, add, result_src=10. ir_write=pc_update=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: a=01, b=01, add (precomputes branch target). Next state by op: lw/sw -> MEMADR; R (0110011) -> EXECUTER; I -> EXECUTEI; beq -> BEQ; other -> FETCH with illegal_instr=1 for this cycle.
  - MEMADR: a=10, b=01, add. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Stay until mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1. Go to FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, held stable until mem_ready. Then go to FETCH.
  - EXECUTER: a=10, b=00, ALUOp=func. Go to ALUWB.
  - EXECUTEI: a=10, b=01, ALUOp=func. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Go to FETCH.
  - BEQ: a=10, b=00, sub, result_src=00, branch=1. Go to FETCH.
- ALU decode:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - ALUOp func, funct3=000: 001 if (funct7b5 AND op[5]), else 000. So addi is never sub.
  - ALUOp func: 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- Cycle counts with zero-wait memory: beq 3; R, I, sw 4; lw 5. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: the FSM abandons the instruction. No write enable is asserted in the cycle reset rises or while it is held. Fetch resumes on the first edge after deassertion.
- Unreachable state encodings go to FETCH on the next edge with all enables 0.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ)
  - ALUOp codes and alu_control codes
  - imm_src codes, also used by the extender
  - mux-select constants
- One sub-module, alu_decoder: combinational; inputs ALUOp, funct3, funct7b5, op5; output alu_control.

Test Plan:
- Reset held 3 cycles mid-MEMWRITE, mem_ready=1 -> mem_write=0 throughout; state FETCH; first ir_write after deassertion.
- add (op=0110011, f3=000, f7b5=0), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB. alu_control=000 in EXECUTER; reg_write=1 only in cycle 4.
- sub R (f7b5=1) -> alu_control=001. addi with instr[30]=1 (op=0010011) -> alu_control=000, imm_src=00, b=01.
- lw with mem_ready low for 2 cycles in MEMREAD -> 7 total cycles; result_src=01 and reg_write=1 only in MEMWB.
- sw -> imm_src=01; mem_write stays 1 until mem_ready rises, then the FSM is in FETCH next cycle.
- beq: zero=1 -> pc_write=1 in BEQ, 3 cycles total, imm_src=10. zero=0 -> pc_write=0 in BEQ.
- op=1111111 -> illegal_instr=1 for exactly one cycle in DECODE; next state FETCH; no reg_write or mem_write.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path and the immediate extender.
package core_ctrl_pkg;

    // Control FSM states; encodings 10..15 are unreachable.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9
    } state_e;

    // Supported opcodes (instr[6:0]).
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALU operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        AluOpAdd  = 2'b00,
        AluOpSub  = 2'b01,
        AluOpFunc = 2'b10
    } alu_op_e;

    // alu_control codes.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format select shared with the extender.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Datapath mux selects.
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format implied by an opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp class plus funct fields to an alu_control code.
module alu_decoder
    import core_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Decode; only R-type (op5=1) with instr[30] set selects sub, so addi never does.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            AluOpAdd: alu_control = ALU_ADD;
            AluOpSub: alu_control = ALU_SUB;
            AluOpFunc: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multi-cycle RV32I core (lw, sw, R, I, beq).
module multicycle_control_fsm
    import core_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       illegal_instr
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_update, branch;
    logic    ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d       = StFetch;
        adr_src       = ADR_PC;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = AluOpAdd;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            StFetch: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                state_d      = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // Precompute the branch target as oldPC + imm.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecuteR;
                    OP_I:         state_d = StExecuteI;
                    OP_BEQ:       state_d = StBeq;
                    default: begin
                        state_d     = StFetch;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_SW) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src = ADR_ALUOUT;
                state_d = mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                result_src    = RES_MEM;
                reg_write_raw = 1'b1;
            end
            StMemWrite: begin
                adr_src       = ADR_ALUOUT;
                mem_write_raw = 1'b1;
                state_d       = mem_ready ? StFetch : StMemWrite;
            end
            StExecuteR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = AluOpFunc;
                state_d   = StAluWb;
            end
            StExecuteI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = AluOpFunc;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write_raw = 1'b1;
            end
            StBeq: begin
                alu_src_a = SRCA_RS1;
                alu_op    = AluOpSub;
                branch    = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

    // Write enables are masked by reset so nothing fires while it is held.
    assign pc_write      = !reset && (pc_update || (branch && zero));
    assign ir_write      = !reset && ir_write_raw;
    assign mem_write     = !reset && mem_write_raw;
    assign reg_write     = !reset && reg_write_raw;
    assign illegal_instr = !reset && illegal_raw;
    assign imm_src       = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       illegal_instr;
    } outs_t;

    outs_t got;
    assign got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                  alu_src_b, alu_control, imm_src, illegal_instr};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BEQ = 7'b1100011;

    int vectors = 0;
    int miscompares = 0;

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic check_outs(input string tag, input outs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model (instruction-level rules) ----------------
    function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BEQ) return 2'b10;
        return 2'b00;
    endfunction

    // Steps an instruction takes with a zero-wait memory.
    function automatic int n_steps(input logic [6:0] o);
        if (o == LW) return 5;
        if (o == SW || o == RT || o == IT) return 4;
        if (o == BEQ) return 3;
        return 2;
    endfunction

    // Step k stalls while mem_ready is low: the fetch and the data access.
    function automatic bit waits_mem(input logic [6:0] o, input int k);
        return (k == 0) || ((o == LW || o == SW) && k == 3);
    endfunction

    function automatic outs_t exp_step(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                       input int k, input logic mr, input logic z);
        outs_t e;
        e = '0;
        e.imm_src = imm_ref(o);
        if (k == 0) begin
            e.alu_src_b  = 2'b10;
            e.result_src = 2'b10;
            e.ir_write   = mr;
            e.pc_write   = mr;
        end else if (k == 1) begin
            e.alu_src_a     = 2'b01;
            e.alu_src_b     = 2'b01;
            e.illegal_instr = (n_steps(o) == 2);
        end else if (o == BEQ) begin
            e.alu_src_a   = 2'b10;
            e.alu_control = 3'b001;
            e.pc_write    = z;
        end else if (o == LW || o == SW) begin
            if (k == 2) begin
                e.alu_src_a = 2'b10;
                e.alu_src_b = 2'b01;
            end else if (k == 3) begin
                e.adr_src   = 1'b1;
                e.mem_write = (o == SW);
            end else begin
                e.result_src = 2'b01;
                e.reg_write  = 1'b1;
            end
        end else begin
            if (k == 2) begin
                e.alu_src_a   = 2'b10;
                e.alu_src_b   = (o == IT) ? 2'b01 : 2'b00;
                e.alu_control = alu_ref(o, f3, f7);
            end else begin
                e.reg_write = 1'b1;
            end
        end
        return e;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         waits;
        int         cycles;
        logic [1:0] imm;
        logic [2:0] alu3;
        bit         wr;
        int         memw;
        int         pcw;
        int         ill;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int w, input int cyc, input logic [1:0] imm,
                       input logic [2:0] alu3, input bit wr, input int memw, input int pcw,
                       input int ill);
        vec_t v;
        v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.waits = w; v.cycles = cyc;
        v.imm = imm; v.alu3 = alu3; v.wr = wr; v.memw = memw; v.pcw = pcw; v.ill = ill;
        tbl.push_back(v);
    endtask

    // Entered at a negedge where the fetch of this instruction shows ir_write=1;
    // returns at the negedge of the following fetch.
    task automatic run_vec(input vec_t v);
        int c, regmask, memw, pcw, ill, imm_seen, alu_seen;
        bit done;
        pcw = int'(pc_write);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
        c = 1; regmask = 0; memw = 0; ill = 0; imm_seen = -1; alu_seen = -1; done = 0;
        while (!done) begin
            @(posedge clk); #1;
            c++;
            mem_ready = (c >= 4 && c < 4 + v.waits) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (ir_write) begin
                done = 1;
            end else if (c > 30) begin
                $display("FAIL %s_timeout: no refetch after %0d cycles, required %0d",
                         v.name, c, v.cycles);
                miscompares++;
                finish_run();
            end else begin
                if (c == 2) imm_seen = int'(imm_src);
                if (c == 3) alu_seen = int'(alu_control);
                regmask |= int'(reg_write) << (c - 1);
                memw += int'(mem_write);
                pcw  += int'(pc_write);
                ill  += int'(illegal_instr);
            end
        end
        check_int({v.name, "_cycles"}, c - 1, v.cycles);
        check_int({v.name, "_imm_src"}, imm_seen, int'(v.imm));
        if (v.cycles >= 3) check_int({v.name, "_alu_control"}, alu_seen, int'(v.alu3));
        check_int({v.name, "_reg_write_mask"}, regmask, v.wr ? (1 << (v.cycles - 1)) : 0);
        check_int({v.name, "_mem_write_cycles"}, memw, v.memw);
        check_int({v.name, "_pc_write_count"}, pcw, v.pcw);
        check_int({v.name, "_illegal_count"}, ill, v.ill);
    endtask

    // ---------------- randomized instructions vs model ----------------
    // Entered at posedge+1 with the FSM in fetch.
    task automatic run_random_instr();
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7, mr;
        int         k, stalls;
        case ($urandom_range(0, 5))
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = IT;
            4: o = BEQ;
            default: begin
                o = 7'($urandom);
                if (o == LW || o == SW || o == RT || o == IT || o == BEQ) o = 7'b1111111;
            end
        endcase
        f3 = 3'($urandom);
        f7 = 1'($urandom);
        op = o; funct3 = f3; funct7b5 = f7;
        k = 0; stalls = 0;
        while (k < n_steps(o)) begin
            if (waits_mem(o, k)) mr = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            else mr = 1'($urandom);
            mem_ready = mr;
            zero = 1'($urandom);
            @(negedge clk);
            check_outs($sformatf("rand_op%b_step%0d", o, k), exp_step(o, f3, f7, k, mr, zero));
            @(posedge clk); #1;
            if (waits_mem(o, k) && !mr) stalls++;
            else begin
                k++;
                stalls = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        miscompares++;
        finish_run();
    end

    initial begin
        //            name     op   f3      f7 z  w cyc imm    alu     wr memw pcw ill
        add("add",    RT,  3'b000, 0, 0, 0, 4, 2'b00, 3'b000, 1, 0, 1, 0);
        add("sub",    RT,  3'b000, 1, 0, 0, 4, 2'b00, 3'b001, 1, 0, 1, 0);
        add("slt",    RT,  3'b010, 0, 1, 0, 4, 2'b00, 3'b101, 1, 0, 1, 0);
        add("or",     RT,  3'b110, 1, 0, 0, 4, 2'b00, 3'b011, 1, 0, 1, 0);
        add("and",    RT,  3'b111, 0, 0, 0, 4, 2'b00, 3'b010, 1, 0, 1, 0);
        add("sll",    RT,  3'b001, 0, 0, 0, 4, 2'b00, 3'b000, 1, 0, 1, 0);
        add("addi30", IT,  3'b000, 1, 0, 0, 4, 2'b00, 3'b000, 1, 0, 1, 0);
        add("slti",   IT,  3'b010, 0, 0, 0, 4, 2'b00, 3'b101, 1, 0, 1, 0);
        add("andi",   IT,  3'b111, 1, 0, 0, 4, 2'b00, 3'b010, 1, 0, 1, 0);
        add("lw",     LW,  3'b010, 0, 0, 0, 5, 2'b00, 3'b000, 1, 0, 1, 0);
        add("lw_w2",  LW,  3'b010, 1, 0, 2, 7, 2'b00, 3'b000, 1, 0, 1, 0);
        add("sw",     SW,  3'b010, 0, 0, 0, 4, 2'b01, 3'b000, 0, 1, 1, 0);
        add("sw_w3",  SW,  3'b010, 0, 1, 3, 7, 2'b01, 3'b000, 0, 4, 1, 0);
        add("beq_z1", BEQ, 3'b000, 0, 1, 0, 3, 2'b10, 3'b001, 0, 0, 2, 0);
        add("beq_z0", BEQ, 3'b000, 1, 0, 0, 3, 2'b10, 3'b001, 0, 0, 1, 0);
        add("ill_7f", 7'b1111111, 3'b000, 0, 0, 0, 2, 2'b00, 3'b000, 0, 0, 1, 1);
        add("ill_00", 7'b0000000, 3'b111, 1, 1, 0, 2, 2'b00, 3'b000, 0, 0, 1, 1);

        // Power-on reset: fetch values with every enable masked.
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset_hold", exp_step(RT, 3'b000, 1'b0, 0, 1'b0, 1'b0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_outs("first_fetch", exp_step(RT, 3'b000, 1'b0, 0, 1'b1, 1'b0));

        foreach (tbl[i]) run_vec(tbl[i]);
        mem_ready = 1'b0;
        @(posedge clk); #1;

        // Reset held for 3 cycles in the middle of a store.
        op = SW; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_outs("sw_memwrite", exp_step(SW, 3'b010, 1'b0, 3, 1'b0, 1'b0));
        mem_ready = 1'b1;
        reset = 1'b1;
        #1 check_outs("reset_rise", exp_step(SW, 3'b010, 1'b0, 0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_outs($sformatf("reset_held_%0d", i), exp_step(SW, 3'b010, 1'b0, 0, 1'b0, 1'b0));
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_outs("refetch_after_reset", exp_step(SW, 3'b010, 1'b0, 0, 1'b1, 1'b0));
        mem_ready = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) run_random_instr();

        finish_run();
    end

endmodule
